// File: rtl/pc_sequencer_if.sv
// Next-PC offer channel between the PC sequencer (master) and the IFU (slave).
interface pc_sequencer_if;
    logic [63:0] npc;
    logic        IFU_valid;
    logic        IFU_ready;
    logic        pred_taken;

    modport master (output npc, output IFU_valid, output pred_taken, input IFU_ready);
    modport slave  (input npc, input IFU_valid, input pred_taken, output IFU_ready);
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC generation: static JAL/BTFN prediction, execute redirects and wrong-path squash.
module pc_sequencer #(
    parameter bit PREDICT_JAL = 1'b1,
    parameter bit PREDICT_BR  = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_done,
    input  logic [63:0]         fetch_pc,
    input  logic [31:0]         fetch_inst,
    input  logic                redirect_valid,
    input  logic [63:0]         redirect_pc,
    pc_sequencer_if.master      ifu,
    output logic                squash,
    output logic                proto_err,
    output logic [CNT_W-1:0]    n_redirect,
    output logic [CNT_W-1:0]    n_squash
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] npc_q, npc_nxt;
    logic        pred_q, pred_nxt;
    logic [63:0] tgt_q, tgt_nxt;
    logic        proto_err_nxt;

    logic [63:0] j_imm;
    logic [63:0] b_imm;
    logic [63:0] pred_pc;
    logic        pred_hit;
    logic        is_jal;
    logic        is_back_br;

    assign j_imm = {{43{fetch_inst[31]}}, fetch_inst[31], fetch_inst[19:12],
                    fetch_inst[20], fetch_inst[30:21], 1'b0};
    assign b_imm = {{51{fetch_inst[31]}}, fetch_inst[31], fetch_inst[7],
                    fetch_inst[30:25], fetch_inst[11:8], 1'b0};

    assign is_jal     = PREDICT_JAL && (fetch_inst[6:0] == 7'b1101111);
    assign is_back_br = PREDICT_BR && (fetch_inst[6:0] == 7'b1100011) && fetch_inst[31];

    always_comb begin
        pred_pc  = fetch_pc + 64'd4;
        pred_hit = 1'b0;
        if (is_jal) begin
            pred_pc  = fetch_pc + j_imm;
            pred_hit = 1'b1;
        end else if (is_back_br) begin
            pred_pc  = fetch_pc + b_imm;
            pred_hit = 1'b1;
        end
    end

    // Held off during reset so decode never drops an instruction on a stale state value.
    assign squash = fetch_done && !rst &&
                    ((state == REDIR) || ((state == IDLE) && redirect_valid));

    assign proto_err_nxt = proto_err | ((state == OFFER) & fetch_done);

    always_comb begin
        state_nxt = state;
        npc_nxt   = npc_q;
        pred_nxt  = pred_q;
        tgt_nxt   = tgt_q;
        case (state)
            IDLE: begin
                if (fetch_done && redirect_valid) begin
                    state_nxt = OFFER;
                    npc_nxt   = redirect_pc;
                    pred_nxt  = 1'b0;
                end else if (redirect_valid) begin
                    state_nxt = REDIR;
                    tgt_nxt   = redirect_pc;
                end else if (fetch_done) begin
                    state_nxt = OFFER;
                    npc_nxt   = pred_pc;
                    pred_nxt  = pred_hit;
                end
            end
            OFFER: begin
                // A redirect racing the accepting edge loses: the old npc is already fetched.
                if (redirect_valid && ifu.IFU_ready) begin
                    state_nxt = REDIR;
                    tgt_nxt   = redirect_pc;
                end else if (redirect_valid) begin
                    npc_nxt  = redirect_pc;
                    pred_nxt = 1'b0;
                end else if (ifu.IFU_ready) begin
                    state_nxt = IDLE;
                end
            end
            REDIR: begin
                if (fetch_done) begin
                    state_nxt = OFFER;
                    npc_nxt   = redirect_valid ? redirect_pc : tgt_q;
                    pred_nxt  = 1'b0;
                end else if (redirect_valid) begin
                    tgt_nxt = redirect_pc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            npc_q     <= '0;
            pred_q    <= 1'b0;
            tgt_q     <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            npc_q     <= npc_nxt;
            pred_q    <= pred_nxt;
            tgt_q     <= tgt_nxt;
            proto_err <= proto_err_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_redirect <= '0;
            n_squash   <= '0;
        end else begin
            if (redirect_valid) begin
                n_redirect <= n_redirect + 1'b1;
            end
            if (squash) begin
                n_squash <= n_squash + 1'b1;
            end
        end
    end

    assign ifu.npc        = npc_q;
    assign ifu.pred_taken = pred_q;
    assign ifu.IFU_valid  = (state == OFFER);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: offered npc values are queued when stimulus is driven and checked at IFU handshakes.
module tb_pc_sequencer;

    typedef struct packed {
        logic [63:0] npc;
        logic        pred;
    } exp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] npc;
        logic        pred;
    } pred_vec_t;

    logic        clk;
    logic        rst;
    logic        fetch_done;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        squash;
    logic        proto_err;
    logic [31:0] n_redirect;
    logic [31:0] n_squash;

    pc_sequencer_if ifu_bus ();

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_done     (fetch_done),
        .fetch_pc       (fetch_pc),
        .fetch_inst     (fetch_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifu            (ifu_bus.master),
        .squash         (squash),
        .proto_err      (proto_err),
        .n_redirect     (n_redirect),
        .n_squash       (n_squash)
    );

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_nred;
    logic [31:0] exp_nsq;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every accepted npc must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && ifu_bus.IFU_valid === 1'b1 && ifu_bus.IFU_ready === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL sb_underflow: handshake npc=%h pred=%b, want no handshake", ifu_bus.npc, ifu_bus.pred_taken);
            end else begin
                mon_e = sb.pop_front();
                if (ifu_bus.npc !== mon_e.npc || ifu_bus.pred_taken !== mon_e.pred) begin
                    n_fail++;
                    $display("[TB] FAIL sb_npc: got npc=%h pred=%b want npc=%h pred=%b",
                             ifu_bus.npc, ifu_bus.pred_taken, mon_e.npc, mon_e.pred);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_done = 1'b1;
        redirect_valid = 1'b1;
        fetch_pc = 64'h8000_0000;
        fetch_inst = 32'h0000_0013;
        redirect_pc = 64'h1234;
        ifu_bus.IFU_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b want 0", ifu_bus.IFU_valid); end
        n_cmp++; if (ifu_bus.npc !== 64'h0) begin n_fail++; $display("[TB] FAIL rst_npc: got %h want 0", ifu_bus.npc); end
        n_cmp++; if (ifu_bus.pred_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pred: got %b want 0", ifu_bus.pred_taken); end
        n_cmp++; if (squash !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_squash: got %b want 0", squash); end
        n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_proto: got %b want 0", proto_err); end
        n_cmp++; if (n_redirect !== 32'd0 || n_squash !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_cnt: got %0d/%0d want 0/0", n_redirect, n_squash); end
        fetch_done = 1'b0;
        redirect_valid = 1'b0;
        ifu_bus.IFU_ready = 1'b0;
        tick();
        rst = 1'b0;
        exp_nred = 32'd0;
        exp_nsq = 32'd0;
        tick();
    endtask

    task automatic test_sequential();
        ifu_bus.IFU_ready = 1'b1;
        fetch_done = 1'b1;
        fetch_pc = 64'h8000_0000;
        fetch_inst = 32'h0000_0013;
        sb.push_back('{npc: 64'h8000_0004, pred: 1'b0});
        @(negedge clk);
        n_cmp++; if (squash !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_squash: got %b want 0", squash); end
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_early_valid: got %b want 0", ifu_bus.IFU_valid); end
        tick();
        fetch_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_valid: got %b want 1", ifu_bus.IFU_valid); end
        tick();
        @(negedge clk);
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_drop: got %b want 0", ifu_bus.IFU_valid); end
        tick();
    endtask

    task automatic test_prediction();
        pred_vec_t vec[5];
        vec[0] = '{pc: 64'h8000_0000, inst: 32'h0100_006F, npc: 64'h8000_0010, pred: 1'b1};
        vec[1] = '{pc: 64'h8000_0008, inst: 32'hFE00_0EE3, npc: 64'h8000_0004, pred: 1'b1};
        vec[2] = '{pc: 64'h8000_0040, inst: 32'h0000_0463, npc: 64'h8000_0044, pred: 1'b0};
        vec[3] = '{pc: 64'hFFFF_FFFF_FFFF_FFFC, inst: 32'h0000_0013, npc: 64'h0, pred: 1'b0};
        vec[4] = '{pc: 64'h0000_1000, inst: 32'hFFF0_0013, npc: 64'h0000_1004, pred: 1'b0};
        ifu_bus.IFU_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_done = 1'b1;
            fetch_pc = vec[i].pc;
            fetch_inst = vec[i].inst;
            sb.push_back('{npc: vec[i].npc, pred: vec[i].pred});
            tick();
            fetch_done = 1'b0;
            @(negedge clk);
            n_cmp++; if (ifu_bus.IFU_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL pred_valid[%0d]: got %b want 1", i, ifu_bus.IFU_valid); end
            tick();
        end
    endtask

    task automatic test_redirect_idle();
        ifu_bus.IFU_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1000;
        exp_nred++;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ridle_valid: got %b want 0", ifu_bus.IFU_valid); end
        tick();
        tick();
        fetch_done = 1'b1;
        fetch_pc = 64'h8000_0020;
        fetch_inst = 32'h0000_0013;
        sb.push_back('{npc: 64'h8000_1000, pred: 1'b0});
        exp_nsq++;
        @(negedge clk);
        n_cmp++; if (squash !== 1'b1) begin n_fail++; $display("[TB] FAIL ridle_squash: got %b want 1", squash); end
        tick();
        fetch_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (n_redirect !== exp_nred) begin n_fail++; $display("[TB] FAIL ridle_nred: got %0d want %0d", n_redirect, exp_nred); end
        n_cmp++; if (n_squash !== exp_nsq) begin n_fail++; $display("[TB] FAIL ridle_nsq: got %0d want %0d", n_squash, exp_nsq); end
        tick();
    endtask

    task automatic test_both_idle();
        ifu_bus.IFU_ready = 1'b1;
        fetch_done = 1'b1;
        fetch_pc = 64'h8000_0000;
        fetch_inst = 32'h0100_006F;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_5000;
        sb.push_back('{npc: 64'h8000_5000, pred: 1'b0});
        exp_nred++;
        exp_nsq++;
        @(negedge clk);
        n_cmp++; if (squash !== 1'b1) begin n_fail++; $display("[TB] FAIL both_squash: got %b want 1", squash); end
        tick();
        fetch_done = 1'b0;
        redirect_valid = 1'b0;
        tick();
    endtask

    task automatic test_redirect_offer();
        ifu_bus.IFU_ready = 1'b0;
        fetch_done = 1'b1;
        fetch_pc = 64'h8000_0000;
        fetch_inst = 32'h0000_0013;
        tick();
        fetch_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifu_bus.npc !== 64'h8000_0004) begin n_fail++; $display("[TB] FAIL roff_npc: got %h want 80000004", ifu_bus.npc); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2000;
        sb.push_back('{npc: 64'h8000_2000, pred: 1'b0});
        exp_nred++;
        @(negedge clk);
        n_cmp++; if (ifu_bus.npc !== 64'h8000_0004) begin n_fail++; $display("[TB] FAIL roff_hold: got %h want 80000004", ifu_bus.npc); end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL roff_valid: got %b want 1", ifu_bus.IFU_valid); end
        n_cmp++; if (ifu_bus.npc !== 64'h8000_2000) begin n_fail++; $display("[TB] FAIL roff_replace: got %h want 80002000", ifu_bus.npc); end
        tick();
        ifu_bus.IFU_ready = 1'b1;
        tick();
        ifu_bus.IFU_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL roff_accept: got %b want 0", ifu_bus.IFU_valid); end
        tick();
        fetch_done = 1'b1;
        fetch_pc = 64'h8000_0100;
        fetch_inst = 32'h0000_0013;
        sb.push_back('{npc: 64'h8000_0104, pred: 1'b0});
        tick();
        fetch_done = 1'b0;
        ifu_bus.IFU_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_3000;
        exp_nred++;
        tick();
        ifu_bus.IFU_ready = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL roff_redir: got %b want 0", ifu_bus.IFU_valid); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_4000;
        exp_nred++;
        tick();
        redirect_valid = 1'b0;
        ifu_bus.IFU_ready = 1'b1;
        fetch_done = 1'b1;
        fetch_pc = 64'h8000_0108;
        fetch_inst = 32'h0100_006F;
        sb.push_back('{npc: 64'h8000_4000, pred: 1'b0});
        exp_nsq++;
        @(negedge clk);
        n_cmp++; if (squash !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_squash: got %b want 1", squash); end
        tick();
        fetch_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (n_redirect !== exp_nred || n_squash !== exp_nsq) begin n_fail++; $display("[TB] FAIL roff_cnt: got %0d/%0d want %0d/%0d", n_redirect, n_squash, exp_nred, exp_nsq); end
        tick();
    endtask

    task automatic test_back_to_back();
        ifu_bus.IFU_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_6000;
        exp_nred++;
        tick();
        redirect_pc = 64'h8000_7000;
        fetch_done = 1'b1;
        fetch_pc = 64'h8000_0200;
        fetch_inst = 32'h0000_0013;
        sb.push_back('{npc: 64'h8000_7000, pred: 1'b0});
        exp_nred++;
        exp_nsq++;
        @(negedge clk);
        n_cmp++; if (squash !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_squash: got %b want 1", squash); end
        tick();
        redirect_valid = 1'b0;
        fetch_done = 1'b0;
        tick();
        fetch_done = 1'b1;
        fetch_pc = 64'h8000_0300;
        fetch_inst = 32'hFE00_0EE3;
        sb.push_back('{npc: 64'h8000_02FC, pred: 1'b1});
        tick();
        fetch_done = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (n_redirect !== exp_nred || n_squash !== exp_nsq) begin n_fail++; $display("[TB] FAIL b2b_cnt: got %0d/%0d want %0d/%0d", n_redirect, n_squash, exp_nred, exp_nsq); end
        tick();
    endtask

    task automatic test_reset_proto();
        ifu_bus.IFU_ready = 1'b0;
        fetch_done = 1'b1;
        fetch_pc = 64'h8000_0200;
        fetch_inst = 32'h0000_0013;
        tick();
        fetch_inst = 32'h0100_006F;
        tick();
        fetch_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (proto_err !== 1'b1) begin n_fail++; $display("[TB] FAIL proto_set: got %b want 1", proto_err); end
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b1 || ifu_bus.npc !== 64'h8000_0204) begin n_fail++; $display("[TB] FAIL proto_ignore: got valid=%b npc=%h want valid=1 npc=80000204", ifu_bus.IFU_valid, ifu_bus.npc); end
        tick();
        @(negedge clk);
        n_cmp++; if (proto_err !== 1'b1) begin n_fail++; $display("[TB] FAIL proto_sticky: got %b want 1", proto_err); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (ifu_bus.IFU_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_valid: got %b want 0", ifu_bus.IFU_valid); end
        n_cmp++; if (n_redirect !== 32'd0 || n_squash !== 32'd0) begin n_fail++; $display("[TB] FAIL arst_cnt: got %0d/%0d want 0/0", n_redirect, n_squash); end
        n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_proto: got %b want 0", proto_err); end
        tick();
        rst = 1'b0;
        exp_nred = 32'd0;
        exp_nsq = 32'd0;
        tick();
        ifu_bus.IFU_ready = 1'b1;
        fetch_done = 1'b1;
        fetch_pc = 64'h0;
        fetch_inst = 32'h0000_0013;
        sb.push_back('{npc: 64'h4, pred: 1'b0});
        tick();
        fetch_done = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        exp_nred = 32'd0;
        exp_nsq = 32'd0;
        rst = 1'b1;
        fetch_done = 1'b0;
        fetch_pc = 64'h0;
        fetch_inst = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        ifu_bus.IFU_ready = 1'b0;

        test_reset();
        test_sequential();
        test_prediction();
        test_redirect_idle();
        test_both_idle();
        test_redirect_offer();
        test_back_to_back();
        test_reset_proto();

        n_cmp++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC generation stage directly upstream of the instruction fetch unit. After each fetched instruction is accepted by decode, it computes the next fetch address and offers it to IFU over the `npc`/`IFU_valid`/`IFU_ready` handshake. It predicts `JAL` and backward conditional branches statically, accepts redirects from execute, and flags the single in-flight wrong-path instruction for squashing.

## Interface
- `PREDICT_JAL`, 1: predict `JAL` targets at decode time.
- `PREDICT_BR`, 1: predict backward conditional branches taken (BTFN).
- `CNT_W`, 32: width of the performance counters.

- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_done`  in  1  pulse for IFU→IDU acceptance (`IDU_valid & IDU_ready`).
- `fetch_pc`  in  64  PC of the accepted instruction.
- `fetch_inst`  in  32  accepted instruction word.
- `redirect_valid`  in  1  execute resolved a redirect this cycle.
- `redirect_pc`  in  64  redirect target.
- `npc`  out  64  next fetch address offered to IFU.
- `IFU_valid`  out  1  `npc` is valid.
- `IFU_ready`  in  1  IFU accepts `npc`.
- `pred_taken`  out  1  `npc` came from a static prediction; registered alongside `npc`.
- `squash`  out  1  combinational; the `fetch_done` this cycle is wrong-path and decode must drop it.
- `proto_err`  out  1  sticky; set when `fetch_done` arrives in OFFER.
- `n_redirect`  out  CNT_W  count of redirects; wraps.
- `n_squash`  out  CNT_W  count of squashed fetches; wraps.

## Operation
- **States:**
  - IDLE: a fetch is in flight and correct-path.
  - OFFER: `IFU_valid=1`.
  - REDIR: the fetch in flight is wrong-path; the redirect target is held in `tgt`.
- **Prediction** is applied to `fetch_pc`/`fetch_inst` when `fetch_done` is taken in IDLE:
  - J-imm = sext64({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - B-imm = sext64({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - opcode 1101111 with `PREDICT_JAL` → `npc = fetch_pc + J-imm`, `pred_taken = 1`.
  - opcode 1100011 with `i[31] = 1` and `PREDICT_BR` → `npc = fetch_pc + B-imm`, `pred_taken = 1`.
  - otherwise `npc = fetch_pc + 4`, `pred_taken = 0`.
  - All additions are 64-bit modulo 2^64; wrap at 0xFFFF_FFFF_FFFF_FFFC → 0 is legal.
- **IDLE transitions:**
  - `fetch_done` only → OFFER with the predicted `npc`.
  - `redirect_valid` only → REDIR, `tgt <= redirect_pc`.
  - Both together → `squash = 1`, go to OFFER with `npc = redirect_pc`, `pred_taken = 0`.
- **OFFER transitions:**
  - Handshake (`IFU_valid & IFU_ready`) without redirect → IDLE.
  - Redirect without handshake → stay in OFFER, `npc <= redirect_pc`, `pred_taken <= 0`.
  - Redirect and handshake together → the old `npc` was consumed, so go to REDIR with `tgt <= redirect_pc`.
  - `fetch_done` → ignored, and `proto_err <= 1`.
- **REDIR transitions:**
  - `fetch_done` → `squash = 1`, go to OFFER with `npc = tgt` (or `redirect_pc` if a redirect arrives in the same cycle), `pred_taken = 0`.
  - Redirect without `fetch_done` → `tgt <= redirect_pc`; the latest redirect wins.
- `squash = fetch_done & ((state==REDIR) | (state==IDLE & redirect_valid))`.
- `n_redirect` increments on every `redirect_valid`; `n_squash` increments on every `squash`.

## Timing
- **Reset:** `rst` asserted at any time, including mid-handshake, clears the block asynchronously. Deasserted, the block starts in IDLE, since IFU fetches its reset PC itself.
  - state = IDLE, `npc = 0`, `IFU_valid = 0`, `pred_taken = 0`.
  - `proto_err = 0`, `n_redirect = 0`, `n_squash = 0`, `tgt = 0`.
  - `squash = 0` while in reset.
- **Latency:** `fetch_done` at edge N → `IFU_valid = 1` and `npc` valid after edge N+1.
- **Handshake:** `npc` and `pred_taken` hold stable while `IFU_valid & !IFU_ready`, except when a redirect replaces them. `IFU_valid` drops after the accepting edge.
- **Throughput:** with `IFU_ready` held high, OFFER lasts exactly one cycle.
- **Priority:** redirect takes precedence over prediction in every state.

## Test plan
- **Sequential fetch:** reset, then `fetch_done` with pc=0x80000000, inst=0x00000013 → next cycle `npc = 0x80000004`, `IFU_valid = 1`, `pred_taken = 0`. With `IFU_ready = 1`, `IFU_valid = 0` on the following cycle.
- **JAL prediction:** inst=0x0100006F (jal x0,+16) at 0x80000000 → `npc = 0x80000010`, `pred_taken = 1`.
- **Backward-branch prediction:** inst=0xFE000EE3 (beq x0,x0,-4) at 0x80000008 → `npc = 0x80000004`, `pred_taken = 1`.
- **Redirect in IDLE:** redirect_pc=0x80001000 in IDLE, then `fetch_done` 3 cycles later:
  - `squash = 1` in that cycle;
  - `npc = 0x80001000` next cycle;
  - `n_redirect = 1`, `n_squash = 1`.
- **Redirect in OFFER:**
  - With `IFU_ready = 0`: redirect replaces `npc` with 0x80002000 and `IFU_valid` stays 1.
  - With `IFU_ready = 1` in the same cycle: the state enters REDIR.
- **Reset and protocol error:**
  - `rst` pulse while in OFFER → `IFU_valid = 0` immediately (asynchronous), counters = 0.
  - `fetch_done` in OFFER → `proto_err = 1`, and it stays set until reset.
